// File: rtl/conclove_mem_pkg.sv
// Shared types and constants for the correlator scratch-memory responder.
package conclove_mem_pkg;

  // Responder FSM encoding; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_DEPTH_WORDS  = 1024;
  localparam int DEF_WAIT_STATES  = 1;
  localparam int DEF_READ_LATENCY = 2;

  // Wait and latency counters are 4 bits wide and saturate at this value.
  localparam logic [3:0] CNT_MAX = 4'hF;

  // Byte address to 32-bit word index; the two lane-select bits are dropped.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/conclove_mem_responder_if.sv
// Avalon-MM s1 bus between the correlator master and the scratch-memory responder.
//
// Handshake: a command (read or write) is issued by the master and must be held
// stable, together with address/writedata/byteenable, for as long as waitrequest
// is 1. The command is accepted in the cycle where the command is asserted and
// waitrequest is 0; the responder samples the bus only in that cycle. A read
// returns data in the single cycle where readdatavalid is 1. addr_err pulses in
// the accept cycle of an out-of-range or read+write command.
interface conclove_mem_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  avs_s1_read;
  logic                  avs_s1_write;
  logic [ADDR_WIDTH-1:0] avs_s1_address;
  logic [31:0]           avs_s1_writedata;
  logic [3:0]            avs_s1_byteenable;
  logic                  avs_s1_waitrequest;
  logic                  avs_s1_readdatavalid;
  logic [31:0]           avs_s1_readdata;
  logic                  addr_err;

  modport slave (
    input  avs_s1_read, avs_s1_write, avs_s1_address, avs_s1_writedata, avs_s1_byteenable,
    output avs_s1_waitrequest, avs_s1_readdatavalid, avs_s1_readdata, addr_err
  );

  modport master (
    output avs_s1_read, avs_s1_write, avs_s1_address, avs_s1_writedata, avs_s1_byteenable,
    input  avs_s1_waitrequest, avs_s1_readdatavalid, avs_s1_readdata, addr_err
  );
endinterface

// File: rtl/conclove_word_ram.sv
// DEPTH x 32 synchronous RAM, byte-enabled write, one registered read port.
// A read of the word being written in the same cycle sees the new lanes.
module conclove_word_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d, rdata_q;

  // Storage write: only enabled lanes change; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read word with write-first bypass of lanes being written this cycle.
  always_comb begin
    rdata_d = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) rdata_d[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Output register: updates only on a read so the word is held in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conclove_mem_responder.sv
// Avalon-MM scratch-memory responder: wait-stated command acceptance, one
// outstanding read with fixed latency, byte-enabled writes, range checking.
module conclove_mem_responder
  import conclove_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES  = DEF_WAIT_STATES,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                              clk,
  input  logic                              rst,
  conclove_mem_responder_if.slave           bus,
  output state_t                            dbg_state
);

  localparam int         RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS4    = 4'(WAIT_STATES);
  localparam logic [3:0] RL4    = 4'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic        oor_q, oor_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           widx;
  logic                  in_range;
  logic [RAM_AW-1:0]     ram_addr;
  logic                  cmd, conflict;
  logic                  accept, wait_req, rvalid;
  logic                  do_write, do_read;
  logic [31:0]           ram_rdata, rd_src;

  assign addr     = bus.avs_s1_address;
  assign widx     = word_index(32'(addr));
  assign in_range = (widx < 32'(DEPTH_WORDS));
  assign ram_addr = widx[RAM_AW-1:0];
  assign cmd      = bus.avs_s1_read | bus.avs_s1_write;
  assign conflict = bus.avs_s1_read & bus.avs_s1_write;

  // Next-state, counters and handshake outputs of the responder FSM.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    lcnt_d   = lcnt_q;
    wait_req = 1'b0;
    accept   = 1'b0;
    rvalid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd) begin
          if (WAIT_STATES == 0) begin
            accept = 1'b1;
          end else begin
            wait_req = 1'b1;
            wcnt_d   = 4'd1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!cmd) begin
          // Master abandoned the command: nothing is performed.
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q >= WS4) begin
          accept  = 1'b1;
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_req = 1'b1;
          wcnt_d   = (wcnt_q == CNT_MAX) ? CNT_MAX : wcnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        // Only one read may be outstanding, so stall everything here.
        wait_req = 1'b1;
        if (lcnt_q <= 4'd1) begin
          rvalid  = 1'b1;
          lcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lcnt_d = lcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
        lcnt_d  = '0;
      end
    endcase
    // While reset is asserted nothing can be accepted and the bus is stalled.
    if (!rst) begin
      accept   = 1'b0;
      wait_req = 1'b1;
    end
    if (accept && bus.avs_s1_read && !bus.avs_s1_write) begin
      state_d = ST_RESP;
      lcnt_d  = RL4;
    end
  end

  assign do_write = accept & bus.avs_s1_write;
  assign do_read  = accept & bus.avs_s1_read & ~bus.avs_s1_write;

  // Remember whether the accepted read was out of range so it returns zero.
  always_comb begin
    oor_d = oor_q;
    if (do_read) oor_d = ~in_range;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      oor_q   <= oor_d;
    end
  end

  conclove_word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (do_write & in_range),
    .be    (bus.avs_s1_byteenable),
    .waddr (ram_addr),
    .wdata (bus.avs_s1_writedata),
    .re    (do_read & in_range),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  assign rd_src = oor_q ? 32'h0 : ram_rdata;

  // RAM output is one cycle after accept; the rest of the latency is delay stages.
  if (READ_LATENCY <= 1) begin : g_no_pipe
    assign bus.avs_s1_readdata = rd_src;
  end else begin : g_pipe
    localparam int NSTG = READ_LATENCY - 1;
    logic [31:0] pipe_q [NSTG];
    logic [31:0] pipe_d [NSTG];

    // Shift the read word along the delay line.
    always_comb begin
      pipe_d[0] = rd_src;
      for (int i = 1; i < NSTG; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Delay-line registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < NSTG; i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < NSTG; i++) pipe_q[i] <= pipe_d[i];
      end
    end

    assign bus.avs_s1_readdata = pipe_q[NSTG-1];
  end

  assign bus.avs_s1_waitrequest   = wait_req;
  assign bus.avs_s1_readdatavalid = rvalid;
  assign bus.addr_err             = accept & (conflict | ~in_range);
  assign dbg_state                = state_q;

endmodule
